// File: rtl/bias_stream_sched_pkg.sv
// Shared layer sizes, bias word width and scheduler state encoding for bias_stream_sched.
package bias_stream_sched_pkg;

  localparam int coeff_width = 16;
  localparam int kern_s_k_N  = 16;
  localparam int out_pix_N   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Counter/address width that stays at least one bit for a depth of 1.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/bias_sched_fifo2.sv
// Two-entry output FIFO between the bias ROM read port and the output stream.
module bias_sched_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset on purpose so the stream data reads 0 out of reset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bias_stream_sched.sv
// Bias ROM sequencer: streams NUM_CH words NUM_REP times per ap_start with full backpressure.
// Optional stall cycle counter output enabled by defining BIAS_SCHED_STALL_CNT_EN.
module bias_stream_sched
  import bias_stream_sched_pkg::*;
#(
  parameter int  NUM_CH  = kern_s_k_N,
  parameter int  NUM_REP = out_pix_N,
  parameter int  DATA_W  = coeff_width,
  localparam int ADDR_W  = addr_w(NUM_CH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] bias_V_address0,
  output logic              bias_V_ce0,
  input  logic [DATA_W-1:0] bias_V_q0,
  output logic [DATA_W-1:0] output_V_din,
  input  logic              output_V_full_n,
  output logic              output_V_write
`ifdef BIAS_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int REP_W = addr_w(NUM_REP);

  sched_state_e     state, state_nxt;
  logic [ADDR_W-1:0] ch_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              inflight;
  logic [1:0]        count;
  logic [2:0]        outstanding;
  logic              pop, issue, last_read, start_acc, drain_empty;

  assign start_acc   = (state == ST_IDLE) && ap_start;
  assign pop         = (count != 2'd0) && output_V_full_n;
  assign outstanding = {1'b0, count} + {2'b00, inflight};
  // Credit check: words in the FIFO plus the read in flight, less this cycle's pop, must leave room.
  assign issue       = (state == ST_RUN) && (outstanding < 3'd2 + {2'b00, pop});
  assign last_read   = (ch_cnt == ADDR_W'(NUM_CH - 1)) && (rep_cnt == REP_W'(NUM_REP - 1));
  assign drain_empty = !inflight && (count == {1'b0, pop});

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    else           state <= state_nxt;
  end

  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ap_start) state_nxt = ST_RUN;
      ST_RUN:   if (issue && last_read) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ch_cnt   <= '0;
      rep_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (start_acc) begin
        ch_cnt  <= '0;
        rep_cnt <= '0;
      end else if (issue) begin
        // Explicit wrap so non-power-of-two channel counts never address past the ROM.
        if (ch_cnt == ADDR_W'(NUM_CH - 1)) begin
          ch_cnt  <= '0;
          rep_cnt <= (rep_cnt == REP_W'(NUM_REP - 1)) ? '0 : rep_cnt + REP_W'(1);
        end else begin
          ch_cnt <= ch_cnt + ADDR_W'(1);
        end
      end
    end
  end

  bias_sched_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (bias_V_q0),
    .head  (output_V_din),
    .count (count)
  );

  assign ap_idle         = (state == ST_IDLE);
  assign ap_done         = (state == ST_DONE);
  assign ap_ready        = ap_done;
  assign bias_V_ce0      = issue;
  assign bias_V_address0 = ch_cnt;
  assign output_V_write  = pop;

`ifdef BIAS_SCHED_STALL_CNT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state == ST_RUN || state == ST_DRAIN) && count != 2'd0 &&
                 !output_V_full_n && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bias_stream_sched.sv
// Self-checking bench for bias_stream_sched (NUM_CH=4, NUM_REP=3); covers BIAS_SCHED_STALL_CNT_EN when defined.
module tb_bias_stream_sched;

  localparam int NUM_CH  = 4;
  localparam int NUM_REP = 3;
  localparam int DW      = 16;
  localparam int AW      = 2;
  localparam int TOTAL   = NUM_CH * NUM_REP;
  localparam int MAX_CYC = 400;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_start, ap_idle, ap_done, ap_ready;
  logic [AW-1:0] bias_V_address0;
  logic          bias_V_ce0;
  logic [DW-1:0] bias_V_q0;
  logic [DW-1:0] output_V_din;
  logic          output_V_full_n, output_V_write;
`ifdef BIAS_SCHED_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int last_stalls = 0;

  always #5 ap_clk = ~ap_clk;

  // ROM image 0x0011, 0x0022, 0x0033, 0x0044.
  function automatic logic [DW-1:0] rom_val(input int k);
    return DW'(17 * (k + 1));
  endfunction

  always @(posedge ap_clk) if (bias_V_ce0) bias_V_q0 <= rom_val(int'(bias_V_address0));

  bias_stream_sched #(.NUM_CH(NUM_CH), .NUM_REP(NUM_REP), .DATA_W(DW)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_idle         (ap_idle),
    .ap_done         (ap_done),
    .ap_ready        (ap_ready),
    .bias_V_address0 (bias_V_address0),
    .bias_V_ce0      (bias_V_ce0),
    .bias_V_q0       (bias_V_q0),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write)
`ifdef BIAS_SCHED_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  // Checks every output against a frame model; cycle 0 is the cycle ap_start is first sampled.
  // mode: 0 full_n=1, 1 full_n=0 in cycles 2..20, 2 toggling 1/0, 3 random.
  task automatic run_frame(input int mode, input bit hold, input int abort_writes,
                           output int dut_done_c);
    int issued = 0, written = 0, iss_p1 = 0, iss_p2 = 0;
    int last_wr_c = -10, stalls = 0, avail, outst;
    bit exp_wr, exp_ce, exp_done, fn;
    dut_done_c = -1;
    for (int c = 0; c < MAX_CYC; c++) begin
      case (mode)
        0:       fn = 1'b1;
        1:       fn = !(c >= 2 && c <= 20);
        2:       fn = (c % 2 == 0);
        default: fn = 1'($urandom_range(0, 1));
      endcase
      output_V_full_n = fn;
      ap_start = (c == 0) || hold;
      @(negedge ap_clk);
      avail    = iss_p2 - written;
      outst    = issued - written;
      exp_wr   = (avail > 0) && fn;
      exp_ce   = (c >= 1) && (issued < TOTAL) && (outst - int'(exp_wr) < 2);
      exp_done = (written == TOTAL) && (c == last_wr_c + 1);

      n_tests++;
      if (ap_idle !== (c == 0)) begin
        n_fail++; $display("FAIL idle c=%0d got %b exp %b", c, ap_idle, (c == 0));
      end
      n_tests++;
      if (output_V_write !== exp_wr) begin
        n_fail++; $display("FAIL write c=%0d got %b exp %b", c, output_V_write, exp_wr);
      end
      if (avail > 0) begin
        n_tests++;
        if (output_V_din !== rom_val(written % NUM_CH)) begin
          n_fail++;
          $display("FAIL din c=%0d word=%0d got %h exp %h", c, written, output_V_din,
                   rom_val(written % NUM_CH));
        end
      end
      n_tests++;
      if (bias_V_ce0 !== exp_ce) begin
        n_fail++; $display("FAIL ce0 c=%0d got %b exp %b", c, bias_V_ce0, exp_ce);
      end
      if (exp_ce) begin
        n_tests++;
        if (bias_V_address0 !== AW'(issued % NUM_CH)) begin
          n_fail++;
          $display("FAIL addr c=%0d got %0d exp %0d", c, bias_V_address0, issued % NUM_CH);
        end
      end
      n_tests++;
      if (ap_done !== exp_done || ap_ready !== exp_done) begin
        n_fail++;
        $display("FAIL done c=%0d got done=%b ready=%b exp %b", c, ap_done, ap_ready, exp_done);
      end
`ifdef BIAS_SCHED_STALL_CNT_EN
      if (c == 0 || c == 1 || exp_done) begin
        n_tests++;
        if (stall_cnt !== 32'((c == 1) ? 0 : (c == 0) ? last_stalls : stalls)) begin
          n_fail++;
          $display("FAIL stall_cnt c=%0d got %0d exp %0d", c, stall_cnt,
                   (c == 1) ? 0 : (c == 0) ? last_stalls : stalls);
        end
      end
`endif
      if (ap_done === 1'b1 && dut_done_c < 0) dut_done_c = c;
      if (c >= 1 && avail > 0 && !fn) stalls++;
      if (exp_wr) begin written++; last_wr_c = c; end
      if (exp_ce) issued++;
      iss_p2 = iss_p1;
      iss_p1 = issued;
      if (abort_writes > 0 && written >= abort_writes) begin
        ap_start = 1'b0;
        return;
      end
      if (exp_done || ap_done === 1'b1) begin
        last_stalls = stalls;
        @(posedge ap_clk); #1;
        ap_start = hold;
        return;
      end
      @(posedge ap_clk); #1;
    end
    n_tests++; n_fail++;
    $display("FAIL timeout frame mode=%0d written=%0d", mode, written);
    ap_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0 || bias_V_ce0 !== 1'b0 ||
        bias_V_address0 !== '0 || output_V_write !== 1'b0 || output_V_din !== '0) begin
      n_fail++;
      $display("FAIL %s got idle=%b done=%b ready=%b ce0=%b addr=%0d wr=%b din=%h exp 1 0 0 0 0 0 0000",
               tag, ap_idle, ap_done, ap_ready, bias_V_ce0, bias_V_address0, output_V_write,
               output_V_din);
    end
`ifdef BIAS_SCHED_STALL_CNT_EN
    n_tests++;
    if (stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL %s stall_cnt got %0d exp 0", tag, stall_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 1'b0; output_V_full_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_reset_outputs("reset_hold");
    ap_rst_n = 1'b1;
    last_stalls = 0;
    @(negedge ap_clk);
    check_reset_outputs("reset_release");
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic();
    int dc;
    run_frame(0, 1'b0, 0, dc);
    n_tests++;
    if (dc !== 15) begin n_fail++; $display("FAIL basic_done_cycle got %0d exp 15", dc); end
    @(negedge ap_clk);
    n_tests++;
    if (ap_idle !== 1'b1 || output_V_write !== 1'b0 || ap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_c16 got idle=%b wr=%b done=%b exp 1 0 0", ap_idle, output_V_write, ap_done);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_backpressure();
    int dc;
    run_frame(1, 1'b0, 0, dc);
  endtask

  task automatic test_toggle();
    int dc;
    run_frame(2, 1'b0, 0, dc);
  endtask

  task automatic test_back_to_back();
    int dc;
    run_frame(0, 1'b1, 0, dc);
    run_frame(3, 1'b1, 0, dc);
    run_frame(0, 1'b1, 0, dc);
    ap_start = 1'b0;
    repeat (2) @(posedge ap_clk); #1;
  endtask

  task automatic test_random();
    int dc;
    for (int f = 0; f < 3; f++) begin
      run_frame(3, 1'b0, 0, dc);
      repeat ($urandom_range(0, 2)) @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic test_mid_reset();
    int dc;
    run_frame(0, 1'b0, 5, dc);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset_async");
    repeat (3) begin
      @(negedge ap_clk);
      check_reset_outputs("midreset_hold");
    end
    ap_rst_n = 1'b1;
    last_stalls = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      check_reset_outputs("midreset_after");
    end
    @(posedge ap_clk); #1;
    run_frame(0, 1'b0, 0, dc);
  endtask

  initial begin
    output_V_full_n = 1'b1;
    ap_start = 1'b0;
    ap_rst_n = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_backpressure();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_stream_sched.md
Name: bias_stream_sched

Overview:
Sequencer for a per-layer bias ROM and its output stream. On ap_start it reads the bias ROM (synchronous, 1-cycle read latency) channel by channel. It emits each value on a FIFO-style write stream, repeating the full channel set once per output pixel. It replaces the free-running bias_s_N core and gives the layer controller an ap_start/ap_done handshake and full backpressure tolerance.

Parameters:
NUM_CH, 16, bias entries per pass (output channels); ROM depth; >=1
NUM_REP, 64, passes per frame (output pixels); >=1
DATA_W, 16, bias word width (coeff_width)
ADDR_W, $clog2(NUM_CH) (min 1), ROM address width; derived, not overridden

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  begin frame; sampled only in IDLE
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse after the last word is written
ap_ready  out  1  one-cycle pulse, coincident with ap_done
bias_V_address0  out  ADDR_W  ROM read address
bias_V_ce0  out  1  ROM read enable
bias_V_q0  in  DATA_W  ROM data, valid the cycle after ce0
output_V_din  out  DATA_W  stream data
output_V_full_n  in  1  downstream can accept
output_V_write  out  1  stream write strobe

Behaviour:
- Reset (async, ap_rst_n low): state=IDLE; counters, buffer and in-flight flag cleared.
  - Outputs during and after reset: ap_idle=1, ap_done=0, ap_ready=0, ce0=0, address0=0, write=0, din=0.
  - A reset mid-frame discards buffered and in-flight data; no write occurs after reset is released until a new ap_start.
- States:
  - IDLE: ap_start=1 moves to RUN.
  - RUN: issues reads until all NUM_CH*NUM_REP reads are issued, then moves to DRAIN.
  - DRAIN: waits for in-flight and buffered words to be written. After the final write, moves to DONE.
  - DONE: lasts one cycle, with ap_done=ap_ready=1, then returns to IDLE.
  - ap_start outside IDLE is ignored.
- Counters:
  - ch_cnt runs 0..NUM_CH-1. It wraps to 0 explicitly at NUM_CH-1, including when NUM_CH is not a power of two.
  - rep_cnt runs 0..NUM_REP-1 and increments on each ch_cnt wrap.
  - Both advance on each issued read.
  - bias_V_address0 = ch_cnt.
- Buffer and credit:
  - 2-entry output FIFO. Occupancy count is 0..2; inflight is 0/1 (a read issued last cycle).
  - pop = output_V_write = (count>0) & output_V_full_n.
  - output_V_din = FIFO head; it holds stable while write=0 and count>0.
  - A read is issued (ce0=1) in RUN when count+inflight-pop < 2.
  - bias_V_q0 is pushed in the cycle inflight=1.
  - A push and a pop in the same cycle leave count unchanged; overflow is impossible by construction.
- Latency:
  - ap_start sampled at edge 0 → ce0=1 with address 0 in cycle 1 → q0 pushed at end of cycle 2 → first output_V_write in cycle 3, provided full_n=1.
  - Sustained throughput is 1 word/cycle while full_n stays high.
- Backpressure: with full_n=0, no write occurs, issuing stops once count+inflight=2, and data order is preserved exactly.
- Degenerate case: NUM_CH=1 keeps address 0 for all reads. Total words written per frame is exactly NUM_CH*NUM_REP.
- ce0 is low in IDLE, DRAIN and DONE.

Optional Feature:
BIAS_SCHED_STALL_CNT_EN:
- Defined: adds output port stall_cnt [31:0]. It counts cycles in RUN or DRAIN where count>0 and output_V_full_n=0, saturates at 0xFFFFFFFF, clears on reset and on ap_start acceptance, and holds its value in IDLE.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package (existing layers_sizes/my_types headers): coeff_width, the per-layer kern_s_k_N used for NUM_CH, and the FSM state encoding constants.
- One natural sub-module, bias_sched_fifo2: the 2-entry FIFO with count, push/pop and head output, DATA_W-parameterised.
- The FSM, counters and credit logic stay in the top.

Test Plan:
All scenarios use NUM_CH=4, NUM_REP=3, ROM = 0x0011, 0x0022, 0x0033, 0x0044.
1. full_n=1, ap_start pulse at cycle 0 → 12 writes in cycles 3..14, din = 11,22,33,44 repeated 3×; ap_done=ap_ready=1 in cycle 15 only; ap_idle high again in cycle 16.
2. full_n held 0 from cycle 2 to cycle 20, then 1 → no write while low; ce0 stops after 2 outstanding; full sequence intact, no duplicates or drops; ap_done follows the 12th write.
3. full_n toggling 1,0 every cycle → 12 writes in order; din stable across every stalled cycle.
4. ap_start held high continuously → frames run back-to-back, with one DONE cycle between frames; start pulses during RUN or DRAIN do not restart or corrupt the frame.
5. ap_rst_n asserted asynchronously after the 5th write, released 3 cycles later → all outputs at reset values immediately; no writes until a new ap_start; the next frame starts at 0x0011.
6. With BIAS_SCHED_STALL_CNT_EN, scenario 2 → stall_cnt equals the number of stalled cycles with count>0 (verify against a bench model); it reads 0 after the next ap_start.
